serial_addsub: RTL

- Bit-serial N-bit adder/subtractor built around one existing `fas` full adder/subtractor cell.
- Feeds one operand bit pair per clock into `fas`, LSB first, and keeps the carry/borrow in a flip-flop.
- Collects sum/difference bits into a shift register and reports the result, carry/borrow-out and signed overflow with a start/done handshake.
- Sits directly downstream of operand registers and upstream of any consumer of `result`.

---
 rtl/serial_addsub_pkg.sv | 14 +
 rtl/serial_addsub_fas.sv | 22 ++
 rtl/serial_addsub.sv | 114 +++++++++++
 3 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
// Mode encoding matches the a_ns pin of the fas cell.
package serial_addsub_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic MODE_ADD = 1'b1;
  localparam logic MODE_SUB = 1'b0;

  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/serial_addsub_fas.sv
// One-bit full adder/subtractor cell: a_ns=1 adds with carry, a_ns=0 subtracts with borrow.
// The sum/difference bit is identical in both modes; only the carry/borrow term differs.
module fas
  import serial_addsub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic a_ns,
  output logic s,
  output logic cout
);

  logic w_carry;
  logic w_borrow;

  assign s        = a ^ b ^ cin;
  assign w_carry  = (a & b) | (a & cin) | (b & cin);
  assign w_borrow = (~a & b) | (~a & cin) | (b & cin);
  assign cout     = (a_ns == MODE_ADD) ? w_carry : w_borrow;

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial N-bit add/subtract: one operand bit pair per clock through a single fas cell,
// LSB first, with start/done handshake and registered result, carry/borrow-out and overflow.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         a_ns,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         cout,
  output logic         ovf
);

  localparam int CW = cnt_width(N);

  state_t          r_state;
  state_t          w_next;
  logic [N-1:0]    r_sa;
  logic [N-1:0]    r_sb;
  logic [N-1:0]    r_sr;
  logic            r_mode;
  logic            r_c;
  logic            r_cmsb;
  logic [CW-1:0]   r_cnt;
  logic [N-1:0]    r_result;
  logic            r_cout;
  logic            r_ovf;
  logic            w_s;
  logic            w_co;
  logic            w_last;
  logic [N-1:0]    w_sr_nxt;

  fas u_fas (
    .a    (r_sa[0]),
    .b    (r_sb[0]),
    .cin  (r_c),
    .a_ns (r_mode),
    .s    (w_s),
    .cout (w_co)
  );

  assign w_last   = (r_cnt == CW'(N-1));
  // New bit enters at the MSB; after N shifts the LSB-first bits sit in order.
  assign w_sr_nxt = (r_sr >> 1) | ({{(N-1){1'b0}}, w_s} << (N-1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa     <= '0;
      r_sb     <= '0;
      r_sr     <= '0;
      r_mode   <= 1'b0;
      r_c      <= 1'b0;
      r_cmsb   <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_sa   <= a_in;
          r_sb   <= b_in;
          r_mode <= a_ns;
          r_c    <= 1'b0;
          r_cnt  <= '0;
        end
        RUN: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_sr  <= w_sr_nxt;
          r_c   <= w_co;
          r_cnt <= r_cnt + CW'(1);
          // Carry out of bit N-2 is the carry into the MSB, needed for signed overflow.
          if (r_cnt == CW'(N-2)) r_cmsb <= w_co;
          if (w_last) begin
            r_result <= w_sr_nxt;
            r_cout   <= w_co;
            r_ovf    <= r_cmsb ^ w_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state != IDLE);
  assign done   = (r_state == DONE);
  assign result = r_result;
  assign cout   = r_cout;
  assign ovf    = r_ovf;

endmodule
